// File: rtl/tank_mover_if.sv
// Tank control bus: player inputs toward the tank, pose/status back out.
// TANK_FIRE_EN adds the one-frame fire strobe.
interface tank_mover_if;
    localparam int unsigned KEY_W = 8;
    localparam int unsigned POS_W = 10;
    localparam int unsigned HDG_W = 2;

    logic [KEY_W-1:0] keycode;
    logic             blocked;
    logic             hit;
    logic [POS_W-1:0] TankX;
    logic [POS_W-1:0] TankY;
    logic [HDG_W-1:0] heading;
    logic             moving;
    logic             alive;
`ifdef TANK_FIRE_EN
    logic             fire;
`endif

    modport master (
        output keycode, blocked, hit,
        input  TankX, TankY, heading, moving, alive
`ifdef TANK_FIRE_EN
        , input fire
`endif
    );

    modport slave (
        input  keycode, blocked, hit,
        output TankX, TankY, heading, moving, alive
`ifdef TANK_FIRE_EN
        , output fire
`endif
    );
endinterface

// File: rtl/tank_mover.sv
// Player tank: keyboard-driven movement with clamping, hit/respawn sequencing,
// and an optional cooled-down fire strobe enabled by the TANK_FIRE_EN macro.
module tank_mover #(
    parameter logic [9:0] START_X        = 10'd32,
    parameter logic [9:0] START_Y        = 10'd416,
    parameter logic [1:0] START_HEADING  = 2'd0,
    parameter logic [9:0] STEP           = 10'd1,
    parameter logic [9:0] X_MIN          = 10'd0,
    parameter logic [9:0] X_MAX          = 10'd608,
    parameter logic [9:0] Y_MIN          = 10'd0,
    parameter logic [9:0] Y_MAX          = 10'd448,
    parameter logic [7:0] KEY_UP         = 8'h1A,
    parameter logic [7:0] KEY_DOWN       = 8'h16,
    parameter logic [7:0] KEY_LEFT       = 8'h04,
    parameter logic [7:0] KEY_RIGHT      = 8'h07,
    parameter logic [7:0] KEY_FIRE       = 8'h2C,
    parameter logic [7:0] RESPAWN_FRAMES = 8'd120,
    parameter logic [5:0] COOLDOWN       = 6'd30
) (
    input logic         frame_clk,
    input logic         Reset,
    tank_mover_if.slave bus
);
    localparam int unsigned POS_W = 10;
    localparam int unsigned HDG_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MOVE    = 2'd1,
        ST_RESPAWN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [POS_W-1:0] x_q, x_d, y_q, y_d;
    logic [HDG_W-1:0] heading_q, heading_d;
    logic             moving_q, moving_d;
    logic             alive_q, alive_d;
    logic [CNT_W-1:0] resp_cnt_q, resp_cnt_d;

    logic             dir_valid_c;
    logic [HDG_W-1:0] dir_c;
    logic [POS_W-1:0] tgt_x_c, tgt_y_c;
    logic [POS_W:0]   x_inc_c, y_inc_c;

`ifdef TANK_FIRE_EN
    localparam int unsigned CD_W = 6;
    logic [CD_W-1:0] cool_q, cool_d;
    logic            fire_q, fire_d;
`endif

    // Direction key decode; the fire key and anything else count as no direction.
    always_comb begin
        dir_valid_c = 1'b1;
        dir_c       = heading_q;
        if (bus.keycode == KEY_UP)         dir_c = 2'd0;
        else if (bus.keycode == KEY_RIGHT) dir_c = 2'd1;
        else if (bus.keycode == KEY_DOWN)  dir_c = 2'd2;
        else if (bus.keycode == KEY_LEFT)  dir_c = 2'd3;
        else                               dir_valid_c = 1'b0;
    end

    // Clamped one-step target; 11-bit sums keep the bounds tests free of wrap-around.
    always_comb begin
        tgt_x_c = x_q;
        tgt_y_c = y_q;
        x_inc_c = {1'b0, x_q} + {1'b0, STEP};
        y_inc_c = {1'b0, y_q} + {1'b0, STEP};
        case (dir_c)
            2'd0: tgt_y_c = ({1'b0, y_q} < ({1'b0, Y_MIN} + {1'b0, STEP})) ? Y_MIN : (y_q - STEP);
            2'd1: tgt_x_c = (x_inc_c > {1'b0, X_MAX}) ? X_MAX : x_inc_c[POS_W-1:0];
            2'd2: tgt_y_c = (y_inc_c > {1'b0, Y_MAX}) ? Y_MAX : y_inc_c[POS_W-1:0];
            default: tgt_x_c = ({1'b0, x_q} < ({1'b0, X_MIN} + {1'b0, STEP})) ? X_MIN : (x_q - STEP);
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESPAWN: if (resp_cnt_q == '0) state_d = ST_IDLE;
            default: begin
                if (bus.hit)                             state_d = ST_RESPAWN;
                else if (dir_valid_c && !bus.blocked)    state_d = ST_MOVE;
                else                                     state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath/outputs; hit outranks every key.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        heading_d  = heading_q;
        moving_d   = 1'b0;
        alive_d    = 1'b1;
        resp_cnt_d = resp_cnt_q;
`ifdef TANK_FIRE_EN
        fire_d     = 1'b0;
        cool_d     = (cool_q != '0) ? (cool_q - CD_W'(1)) : cool_q;
`endif
        case (state_q)
            ST_RESPAWN: begin
                alive_d = (resp_cnt_q == '0);
                if (resp_cnt_q != '0) resp_cnt_d = resp_cnt_q - CNT_W'(1);
            end
            default: begin
                if (bus.hit) begin
                    x_d        = START_X;
                    y_d        = START_Y;
                    heading_d  = START_HEADING;
                    alive_d    = 1'b0;
                    resp_cnt_d = RESPAWN_FRAMES - CNT_W'(1);
                end else if (dir_valid_c) begin
                    heading_d = dir_c;
                    if (!bus.blocked) begin
                        x_d      = tgt_x_c;
                        y_d      = tgt_y_c;
                        moving_d = (tgt_x_c != x_q) || (tgt_y_c != y_q);
                    end
`ifdef TANK_FIRE_EN
                end else if ((bus.keycode == KEY_FIRE) && (cool_q == '0)) begin
                    fire_d = 1'b1;
                    cool_d = COOLDOWN;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            x_q        <= START_X;
            y_q        <= START_Y;
            heading_q  <= START_HEADING;
            moving_q   <= 1'b0;
            alive_q    <= 1'b1;
            resp_cnt_q <= '0;
`ifdef TANK_FIRE_EN
            fire_q     <= 1'b0;
            cool_q     <= '0;
`endif
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            heading_q  <= heading_d;
            moving_q   <= moving_d;
            alive_q    <= alive_d;
            resp_cnt_q <= resp_cnt_d;
`ifdef TANK_FIRE_EN
            fire_q     <= fire_d;
            cool_q     <= cool_d;
`endif
        end
    end

    assign bus.TankX   = x_q;
    assign bus.TankY   = y_q;
    assign bus.heading = heading_q;
    assign bus.moving  = moving_q;
    assign bus.alive   = alive_q;
`ifdef TANK_FIRE_EN
    assign bus.fire    = fire_q;
`endif

endmodule

// File: doc/tank_mover.md
TANK_MOVER -- requirements
Module: tank_mover

Interface
REQ-001 SHALL have parameter START_X, default 10'd32, reset/respawn X position.
REQ-002 SHALL have parameter START_Y, default 10'd416, reset/respawn Y position.
REQ-003 SHALL have parameter START_HEADING, default 2'd0, reset/respawn heading (0 up, 1 right, 2 down, 3 left).
REQ-004 SHALL have parameter STEP, default 10'd1, pixels moved per frame.
REQ-005 SHALL have parameters X_MIN/X_MAX/Y_MIN/Y_MAX, defaults 0/608/0/448, inclusive position bounds.
REQ-006 SHALL have parameters KEY_UP/KEY_DOWN/KEY_LEFT/KEY_RIGHT/KEY_FIRE, defaults 8'h1A/8'h16/8'h04/8'h07/8'h2C, the player's keycodes.
REQ-007 SHALL have parameter RESPAWN_FRAMES, default 8'd120, frames spent dead after a hit.
REQ-008 SHALL have parameter COOLDOWN, default 6'd30, frames between shots.
REQ-009 frame_clk  input  1  frame-rate clock, all logic on rising edge.
REQ-010 Reset  input  1  synchronous, active-high reset.
REQ-011 keycode  input  8  current keyboard code, 8'h00 = no key.
REQ-012 blocked  input  1  arena map reports that the next step along the requested direction collides.
REQ-013 hit  input  1  tank was struck this frame.
REQ-014 TankX, TankY  output  10 each  top-left tank position.
REQ-015 heading  output  2  facing direction.
REQ-016 moving  output  1  high when position changed on the last edge.
REQ-017 alive  output  1  high outside RESPAWN.
REQ-018 fire  output  1  one-frame shot request (only with TANK_FIRE_EN).

Function
REQ-019 SHALL implement states IDLE, MOVE, RESPAWN, registered.
REQ-020 In IDLE/MOVE, a direction keycode SHALL set heading immediately; unmatched keycodes SHALL stop motion (state IDLE, moving=0). Motion SHALL NOT persist after the key is released.
REQ-021 Direction key with blocked=0 SHALL move STEP along heading on the same edge, state MOVE, moving=1; with blocked=1, heading updates, position holds, state IDLE, moving=0.
REQ-022 Moves SHALL clamp: left yields max(X-STEP, X_MIN), right yields min(X+STEP, X_MAX), likewise Y; no 10-bit wrap-around; clamped move that changes nothing SHALL give moving=0.
REQ-023 hit=1 in IDLE/MOVE SHALL enter RESPAWN, load counter with RESPAWN_FRAMES-1, set alive=0, moving=0, position/heading to START values.
REQ-024 In RESPAWN, keycode and hit SHALL be ignored; counter decrements per frame; at 0 the next edge enters IDLE, alive=1.
REQ-025 hit SHALL take priority over any simultaneous keycode.

Reset
REQ-026 Reset=1 SHALL on the next edge set TankX=START_X, TankY=START_Y, heading=START_HEADING, state IDLE, moving=0, alive=1, fire=0, cooldown and respawn counters 0, overriding all inputs including mid-RESPAWN.

Configuration
REQ-027 With TANK_FIRE_EN defined: KEY_FIRE in IDLE/MOVE with cooldown=0 SHALL pulse fire=1 for one frame, load cooldown=COOLDOWN, stop motion; cooldown decrements to 0 each frame (also during RESPAWN); fire key with cooldown>0 SHALL be ignored apart from stopping motion.
REQ-028 Without TANK_FIRE_EN: fire port and cooldown counter SHALL be absent; KEY_FIRE behaves as an unmatched keycode.

Verification
REQ-029 Reset, then keycode=8'h07 for 3 frames -> TankX=35, TankY=416, heading=1, moving=1; keycode=0 -> TankX stays 35, moving=0.
REQ-030 X_MIN=0, TankX=1, STEP=4, keycode=8'h04 -> TankX=0; next frame TankX=0, moving=0.
REQ-031 blocked=1 with keycode=8'h1A -> heading=0, TankY unchanged, moving=0.
REQ-032 hit=1 with keycode=8'h07 at TankX=100 -> TankX=32, alive=0 for 120 frames, keys ignored, then alive=1, state IDLE.
REQ-033 TANK_FIRE_EN, keycode=8'h2C held 40 frames -> fire high on frame 1 and frame 32 only.
REQ-034 Reset asserted mid-RESPAWN -> next edge alive=1, position START, fire=0.
